// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path defaults: byte width and default FIFO pointer width.
// The receiver, this FIFO and the future TX FIFO all pick these up.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;

  // Fill level at which a FIFO with the given pointer width reports full.
  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction
endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the RX FIFO: synchronous write port and an
// asynchronous read port. The contents have no reset.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [fifo_depth(ADDR_W)];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver.
// It provides an occupancy count and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun
);
  localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W+1)'(fifo_depth(ADDR_W));
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign w_push  = wr_tick && (!w_full || rd);
  assign w_pop   = rd && !w_empty;
  assign w_drop  = wr_tick && w_full && !rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      // A drop in the same cycle takes priority over a clear request.
      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (rd_data)
  );

  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_tick;
  logic [DW-1:0] wr_data;
  logic          rd;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          clr_overrun;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_ovr;

  typedef struct {
    logic          wt;
    logic [DW-1:0] wd;
    logic          rd;
    logic          clr;
    logic [AW:0]   e_cnt;
    logic          e_empty;
    logic          e_full;
    logic          e_ovr;
    logic          chk_d;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t vecs[8];

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr_tick     (wr_tick),
    .wr_data     (wr_data),
    .rd          (rd),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " count"},   32'(count),   32'(exp_q.size()));
    check({tag, " empty"},   32'(empty),   32'(exp_q.size() == 0));
    check({tag, " full"},    32'(full),    32'(exp_q.size() == DEPTH));
    check({tag, " overrun"}, 32'(overrun), 32'(exp_ovr));
    if (exp_q.size() > 0) check({tag, " rd_data"}, 32'(rd_data), 32'(exp_q[0]));
  endtask

  // driver: apply one cycle of inputs, advance the model, compare outputs
  task automatic cycle(input logic wt, input logic [DW-1:0] wd, input logic r, input logic c,
                       input string tag);
    int  pre_size;
    bit  acc_push, do_pop, drop;
    wr_tick = wt; wr_data = wd; rd = r; clr_overrun = c;
    pre_size = exp_q.size();
    @(posedge clk);
    #1;
    acc_push = wt && (pre_size < DEPTH || r);
    do_pop   = r && pre_size > 0;
    drop     = wt && pre_size == DEPTH && !r;
    if (do_pop) void'(exp_q.pop_front());
    if (acc_push) exp_q.push_back(wd);
    if (drop) exp_ovr = 1'b1;
    else if (c) exp_ovr = 1'b0;
    wr_tick = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
    check_model(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " count"},   32'(count),   32'd0);
    check({tag, " empty"},   32'(empty),   32'd1);
    check({tag, " full"},    32'(full),    32'd0);
    check({tag, " overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    reset = 1'b0; wr_tick = 1'b0; wr_data = '0; rd = 1'b0; clr_overrun = 1'b0;
    exp_ovr = 1'b0;

    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'h5A, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    #12;
    check_reset_values("in_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("after_reset");

    // directed vector table: reset state, pop on empty, basic push/pop, push+pop on empty
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].wt, vecs[i].wd, vecs[i].rd, vecs[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d tbl_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d tbl_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d tbl_ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
      if (vecs[i].chk_d) check($sformatf("vec%0d tbl_data", i), 32'(rd_data), 32'(vecs[i].e_d));
    end

    // fill to 16, overflow push dropped, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, "fill");
    check("fill full", 32'(full), 32'd1);
    check("fill count", 32'(count), 32'd16);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, "overflow");
    check("overflow ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d data", i), 32'(rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    check("drain empty", 32'(empty), 32'd1);

    // full FIFO accepts push when popped in the same cycle
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 8'h77, 1'b1, 1'b0, "full_pushpop");
    check("full_pushpop count", 32'(count), 32'd16);
    check("full_pushpop ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "pop15");
    check("pop15 data", 32'(rd_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "pop_last");

    // overrun set beats clear; clear alone works
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0, "fill5");
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, "drop1");
    cycle(1'b1, 8'hEF, 1'b0, 1'b1, "drop_clr");
    check("drop_clr ovr", 32'(overrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_only");
    check("clr_only ovr", 32'(overrun), 32'd0);

    // steady push/pop around pointer wrap at count=5, then reset mid-stream
    while (exp_q.size() > 5) cycle(1'b0, 8'h00, 1'b1, 1'b0, "trim");
    check("wrap start count", 32'(count), 32'd5);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, "wrap");
    check("wrap end count", 32'(count), 32'd5);
    check("wrap head", 32'(rd_data), 32'h8F);
    wr_tick = 1'b1; wr_data = 8'h99;
    #2 reset = 1'b0;
    #1;
    exp_q.delete(); exp_ovr = 1'b0;
    check_reset_values("midreset");
    wr_tick = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_midreset");

    // randomized traffic: write-heavy phase then read-heavy phase
    for (int i = 0; i < 600; i++) begin
      int wp = (i < 300) ? 70 : 30;
      cycle(logic'($urandom_range(0, 99) < wp), DW'($urandom_range(0, 255)),
            logic'($urandom_range(0, 99) < (100 - wp)), logic'($urandom_range(0, 99) < 5),
            "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
